// File: rtl/pwm_timer_bank.sv
// Multi-channel edge-aligned PWM bank; `PWM_SHADOW_EN` selects double-buffered duty/period updates.
// Latency: PWMOutputs and PeriodWrap are registered, one CLK after the counter state they reflect.
// Backpressure: none; write strobes are always accepted.
module pwm_timer_bank #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 8,
    parameter int PRE_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      _RST,
    input  logic                      Enable,
    input  logic [PRE_WIDTH-1:0]      Prescale,
    input  logic [WIDTH-1:0]          PeriodIn,
    input  logic                      PeriodWrite,
    input  logic [CHANNELS*WIDTH-1:0] DutyIn,
    input  logic [CHANNELS-1:0]       DutyWrite,
    output logic [CHANNELS-1:0]       PWMOutputs,
    output logic                      PeriodWrap
);

    logic [PRE_WIDTH-1:0] pre_q, pre_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     act_period_q, act_period_d;
    logic [WIDTH-1:0]     act_duty_q [CHANNELS];
    logic [WIDTH-1:0]     act_duty_d [CHANNELS];
    logic [CHANNELS-1:0]  pwm_q, pwm_d;
    logic                 wrap_q, wrap_d;
    logic                 tick;
    logic                 wrap_evt;

`ifdef PWM_SHADOW_EN
    logic [WIDTH-1:0]     shadow_period_q, shadow_period_d;
    logic [WIDTH-1:0]     shadow_duty_q [CHANNELS];
    logic [WIDTH-1:0]     shadow_duty_d [CHANNELS];
`endif

    assign tick     = Enable && (pre_q == Prescale);
    // >= rather than == so a period shrunk below the running count still wraps.
    assign wrap_evt = tick && (cnt_q >= act_period_q);

    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        pwm_d  = '0;
        if (!Enable) begin
            pre_d = '0;
            cnt_d = '0;
        end else if (tick) begin
            pre_d  = '0;
            cnt_d  = wrap_evt ? '0 : cnt_q + 1'b1;
            wrap_d = wrap_evt;
        end else begin
            pre_d = pre_q + 1'b1;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = Enable && (cnt_q < act_duty_q[i]);
        end
    end

`ifdef PWM_SHADOW_EN
    // Active set reloads from the old shadow value, so a write on a wrap edge waits a period.
    always_comb begin
        shadow_period_d = PeriodWrite ? PeriodIn : shadow_period_q;
        act_period_d    = (!Enable || wrap_evt) ? shadow_period_q : act_period_q;
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_duty_d[i] = DutyWrite[i] ? DutyIn[i*WIDTH +: WIDTH] : shadow_duty_q[i];
            act_duty_d[i]    = (!Enable || wrap_evt) ? shadow_duty_q[i] : act_duty_q[i];
        end
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            shadow_period_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_duty_q[i] <= '0;
            end
        end else begin
            shadow_period_q <= shadow_period_d;
            shadow_duty_q   <= shadow_duty_d;
        end
    end
`else
    always_comb begin
        act_period_d = PeriodWrite ? PeriodIn : act_period_q;
        for (int i = 0; i < CHANNELS; i++) begin
            act_duty_d[i] = DutyWrite[i] ? DutyIn[i*WIDTH +: WIDTH] : act_duty_q[i];
        end
    end
`endif

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            pre_q        <= '0;
            cnt_q        <= '0;
            act_period_q <= '0;
            pwm_q        <= '0;
            wrap_q       <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                act_duty_q[i] <= '0;
            end
        end else begin
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
            act_period_q <= act_period_d;
            act_duty_q   <= act_duty_d;
            pwm_q        <= pwm_d;
            wrap_q       <= wrap_d;
        end
    end

    assign PWMOutputs = pwm_q;
    assign PeriodWrap = wrap_q;

endmodule

// File: tb/tb_pwm_timer_bank.sv
// Self-checking bench for pwm_timer_bank: directed table, waveform-count sequences, random vs reference model.
module tb_pwm_timer_bank;

`ifdef PWM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  presc;
    logic [7:0]  pin;
    logic        pwr;
    logic [31:0] din;
    logic [3:0]  dwr;
    logic [3:0]  pwm;
    logic        wrap;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_timer_bank #(.CHANNELS(4), .WIDTH(8), .PRE_WIDTH(8)) dut (
        .CLK        (clk),
        ._RST       (rst_n),
        .Enable     (en),
        .Prescale   (presc),
        .PeriodIn   (pin),
        .PeriodWrite(pwr),
        .DutyIn     (din),
        .DutyWrite  (dwr),
        .PWMOutputs (pwm),
        .PeriodWrap (wrap)
    );

    always #5 clk = ~clk;

    // Reference model: timer state as plain integers, advanced once per clock edge.
    int m_pre, m_cnt, m_sh_per, m_act_per, m_out, m_wrap;
    int m_sh_duty [4];
    int m_act_duty [4];

    task automatic model_reset();
        m_pre = 0; m_cnt = 0; m_sh_per = 0; m_act_per = 0; m_out = 0; m_wrap = 0;
        for (int i = 0; i < 4; i++) begin
            m_sh_duty[i] = 0;
            m_act_duty[i] = 0;
        end
    endtask

    task automatic model_edge();
        int nxt;
        bit load;
        nxt = 0;
        load = 1'b0;
        m_wrap = 0;
        if (!en) begin
            m_pre = 0;
            m_cnt = 0;
            load = SHADOW;
        end else begin
            for (int i = 0; i < 4; i++)
                if (m_cnt < m_act_duty[i]) nxt = nxt | (1 << i);
            if (m_pre == int'(presc)) begin
                m_pre = 0;
                if (m_cnt >= m_act_per) begin
                    m_cnt = 0;
                    m_wrap = 1;
                    load = SHADOW;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_pre = (m_pre + 1) % 256;
            end
        end
        m_out = nxt;
        if (load) begin
            m_act_per = m_sh_per;
            for (int i = 0; i < 4; i++) m_act_duty[i] = m_sh_duty[i];
        end
        if (SHADOW) begin
            if (pwr) m_sh_per = int'(pin);
            for (int i = 0; i < 4; i++) if (dwr[i]) m_sh_duty[i] = int'(din[i*8 +: 8]);
        end else begin
            if (pwr) m_act_per = int'(pin);
            for (int i = 0; i < 4; i++) if (dwr[i]) m_act_duty[i] = int'(din[i*8 +: 8]);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("pwm_vs_model", int'(pwm), m_out);
        check("wrap_vs_model", int'(wrap), m_wrap);
        pwr = 1'b0;
        dwr = 4'b0;
    endtask

    int w_hi [4];
    int w_wr;

    task automatic window(input int n);
        for (int c = 0; c < 4; c++) w_hi[c] = 0;
        w_wr = 0;
        for (int k = 0; k < n; k++) begin
            cycle();
            for (int c = 0; c < 4; c++) if (pwm[c]) w_hi[c]++;
            if (wrap) w_wr++;
        end
    endtask

    task automatic set_duty(input int ch, input int val);
        din[ch*8 +: 8] = 8'(val);
        dwr[ch] = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic       wr;
        logic [3:0] exp_out;
        logic       exp_wrap;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(logic e, logic w, logic [3:0] o, logic wp);
        vec_t v;
        v.en = e; v.wr = w; v.exp_out = o; v.exp_wrap = wp;
        return v;
    endfunction

    initial begin
        // Period 9, duties {255,10,0,3}: programmed while disabled, then run from cnt=0.
        tbl[0] = mk(1'b0, 1'b1, 4'b0000, 1'b0);
        tbl[1] = mk(1'b0, 1'b0, 4'b0000, 1'b0);
        for (int r = 2; r <= 4; r++) tbl[r] = mk(1'b1, 1'b0, 4'b1101, 1'b0);
        for (int r = 5; r <= 10; r++) tbl[r] = mk(1'b1, 1'b0, 4'b1100, 1'b0);
        tbl[11] = mk(1'b1, 1'b0, 4'b1100, 1'b1);
        tbl[12] = mk(1'b1, 1'b0, 4'b1101, 1'b0);
        tbl[13] = mk(1'b1, 1'b0, 4'b1101, 1'b0);

        rst_n = 1'b0; en = 1'b0; presc = 8'd0; pin = 8'd0; pwr = 1'b0; din = '0; dwr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pwm", int'(pwm), 0);
        check("reset_wrap", int'(wrap), 0);
        rst_n = 1'b1;

        for (int r = 0; r < 14; r++) begin
            en = tbl[r].en;
            pin = 8'd9;
            din = 32'hFF0A_0003;
            pwr = tbl[r].wr;
            dwr = tbl[r].wr ? 4'hF : 4'h0;
            cycle();
            check($sformatf("tbl_pwm_row%0d", r), int'(pwm), int'(tbl[r].exp_out));
            check($sformatf("tbl_wrap_row%0d", r), int'(wrap), int'(tbl[r].exp_wrap));
        end

        window(20);
        check("basic_ch0_high", w_hi[0], 6);
        check("bound_duty0_high", w_hi[1], 0);
        check("bound_duty10_high", w_hi[2], 20);
        check("bound_duty255_high", w_hi[3], 20);
        check("basic_wraps", w_wr, 2);

        en = 1'b0; presc = 8'd1; pin = 8'd4; pwr = 1'b1; set_duty(0, 2);
        cycle();
        cycle();
        en = 1'b1;
        window(20);
        check("presc_ch0_high", w_hi[0], 8);
        check("presc_ch2_high", w_hi[2], 20);
        check("presc_wraps", w_wr, 2);

        en = 1'b0; presc = 8'd0; pin = 8'd9; pwr = 1'b1; set_duty(0, 3);
        cycle();
        cycle();
        en = 1'b1;
        window(5);
        check("upd_first_high", w_hi[0], 3);
        set_duty(0, 7);
        cycle();
        check("upd_write_edge", int'(pwm[0]), 0);
        cycle();
        check("upd_after_write", int'(pwm[0]), SHADOW ? 0 : 1);
        window(3);
        check("upd_rest_of_period", w_hi[0], 0);
        window(9);
        check("upd_next_period", w_hi[0], 7);

        set_duty(0, 2);
        cycle();
        check("wow_wrap_pulse", int'(wrap), 1);
        window(10);
        check("wow_period_a", w_hi[0], SHADOW ? 7 : 2);
        window(10);
        check("wow_period_b", w_hi[0], 2);

        check("rst_pre_high", int'(pwm[3:2]), 3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_pwm", int'(pwm), 0);
        check("rst_async_wrap", int'(wrap), 0);
        model_reset();
        #1 rst_n = 1'b1;
        window(10);
        check("rst_zero_ch0", w_hi[0], 0);
        check("rst_zero_ch3", w_hi[3], 0);
        check("rst_period0_wraps", w_wr, 10);

        pin = 8'd9; pwr = 1'b1; set_duty(0, 3); set_duty(2, 10);
        window(15);
        en = 1'b0;
        cycle();
        check("en_low_pwm", int'(pwm), 0);
        check("en_low_wrap", int'(wrap), 0);
        en = 1'b1;
        cycle();
        check("en_restart_cnt0", int'(pwm[0]), 1);
        window(10);
        check("en_restart_high", w_hi[0], 3);
        check("en_restart_wraps", w_wr, 1);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 49) == 0) en = ~en;
            if (!en && $urandom_range(0, 3) == 0) presc = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                pin = 8'($urandom_range(0, 12));
                pwr = 1'b1;
            end
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 5) == 0) set_duty(c, $urandom_range(0, 15));
            cycle();
            if ($urandom_range(0, 399) == 0) begin
                #3 rst_n = 1'b0;
                #1;
                check("rand_async_reset", int'(pwm), 0);
                model_reset();
                #1 rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_timer_bank.md
# pwm_timer_bank

Multi-channel PWM timer bank clocked by the main timer clock, sitting directly downstream of the SPI register file in `Main` and driving `PWMOutputs`. It takes per-channel duty values, a shared period and a prescaler from the register file, and generates edge-aligned PWM waveforms. Duty and period updates are double-buffered so that each PWM period completes without glitches.

## Interface
- `CHANNELS`, default 4: number of PWM outputs.
- `WIDTH`, default 8: width of the period, duty and counter values.
- `PRE_WIDTH`, default 8: width of the prescaler value.

- `CLK`, input, 1: main timer clock, rising-edge.
- `_RST`, input, 1: asynchronous active-low reset.
- `Enable`, input, 1: global run enable, level-sensitive.
- `Prescale`, input, PRE_WIDTH: a tick occurs every `Prescale+1` CLK cycles.
- `PeriodIn`, input, WIDTH: period value; the counter runs 0..Period.
- `PeriodWrite`, input, 1: one-cycle strobe that captures `PeriodIn`.
- `DutyIn`, input, CHANNELS*WIDTH: packed duty values; channel i is bits [i*WIDTH +: WIDTH].
- `DutyWrite`, input, CHANNELS: per-channel one-cycle strobe that captures that channel's `DutyIn` slice.
- `PWMOutputs`, output, CHANNELS: registered PWM outputs.
- `PeriodWrap`, output, 1: one-cycle pulse each time the counter wraps.

All inputs are synchronous to `CLK`. Synchronisation from the SCLK domain is done upstream.

## Operation
- **Registers:**
  - Shadow registers: `shadow_period` and `shadow_duty[i]`.
  - Active registers: `act_period` and `act_duty[i]`.
  - Counters: prescaler `pre` and period counter `cnt`.
- **Writes:** the write strobes load only the shadow registers.
- **Enable low:**
  - `pre` and `cnt` are held at 0.
  - `PWMOutputs` is 0 and `PeriodWrap` is 0.
  - The active registers copy the shadow registers every cycle.
- **Enable high, prescaler:** when `pre == Prescale`, a tick is generated and `pre` returns to 0. Otherwise `pre` increments. With `Prescale = 0`, every cycle is a tick.
- **Enable high, on tick:**
  - If `cnt >= act_period`, the counter wraps: `cnt` returns to 0, the active registers load from the shadow registers, and `PeriodWrap` is set to 1 for one cycle.
  - Otherwise `cnt` increments.
  - The `>=` comparison guards against a period that shrinks while running.
- **Output compare:** every cycle, `PWMOutputs[i] <= Enable & (cnt < act_duty[i])`, using the current (pre-update) value of `cnt`.
- **Duty boundaries:**
  - Duty 0 gives a constantly low output.
  - Duty ≥ Period+1 gives a constantly high output.
  - Duty d gives d high ticks out of Period+1.
  - Period 0 gives a constant output: low if duty is 0, high otherwise.
- **Simultaneous write and wrap:** the wrap loads the old shadow value. The new write lands in the shadow register and takes effect at the next wrap.
- **Simultaneous write and Enable low:** the new value is visible in the active register one cycle later.
- **Reset:** asynchronous reset clears every register (shadow, active, `pre`, `cnt`) to 0. `PWMOutputs = 0` and `PeriodWrap = 0`. Reset asserted mid-period aborts the period immediately.

## Timing
- **Output latency:** `PWMOutputs` lags `cnt` by one CLK cycle. `PeriodWrap` rises on the same edge on which `cnt` becomes 0.
- **Enable rise:**
  - The first tick occurs `Prescale+1` cycles after the first cycle with Enable high.
  - `PWMOutputs` reflects `cnt = 0` from the edge after Enable rises.
- **Enable fall:** outputs go low on the next edge.
- **Write-to-effect latency:** from the next wrap (buffered mode), or one cycle (see Configuration).
- **Period length:** (Period+1)*(Prescale+1) CLK cycles.

## Configuration
- **`PWM_SHADOW_EN` defined:** double-buffering is active, as described above.
- **`PWM_SHADOW_EN` undefined:**
  - The shadow registers are removed and the write strobes load the active registers directly.
  - New values affect the output from the next cycle.
  - Mid-period glitches are permitted.
  - The wrap only resets `cnt` and pulses `PeriodWrap`.

## Test plan
- **Basic duty:** reset, then Period=9, Prescale=0, Duty0=3, Enable=1 -> channel 0 is high for 3 of every 10 cycles, and `PeriodWrap` pulses every 10 cycles.
- **Duty boundaries:** Period=9, Duty1=0, Duty2=10, Duty3=255 -> ch1 is constantly 0; ch2 and ch3 are constantly 1 after the first edge.
- **Prescaler:** Prescale=1, Period=4, Duty0=2 -> a 10-cycle period with a 4-cycle high time.
- **Shadow update (with macro):** Duty0 changes from 3 to 7 at `cnt = 5` -> the current period keeps its 3-tick high time, and the next period has a 7-tick high time. Without the macro, the output goes high on the cycle after the write.
- **Write on wrap:** a write on the same edge as the wrap -> the old value is used for one more period.
- **Reset and Enable:** `_RST` low mid-period -> outputs are 0 immediately, without waiting for a clock edge. After release, the shadow and active registers read back as zero behaviour (all outputs low). Enable low -> outputs low on the next edge, and `cnt` restarts from 0 when Enable returns high.
